rc_gearbox256: RTL

- Receive-side counterpart of the RQ gearbox. Accepts requester-completion (RC) TLPs from the PCIe IP core's 256-bit master AXI-stream.
- Each SOP beat carries a 3-DW (96-bit) completion descriptor in DW0-2, with payload starting at DW3. The block strips the descriptor and realigns the payload to DW0.
- Presents the user side with the descriptor, an extracted dword count, and 8-DW-aligned data beats.
- Sits between the PCIe IP RC interface and the DMA read-completion consumer.

---
 rtl/rc_gearbox256.sv | 124 ++++++++++++
 1 files changed

// File: rtl/rc_gearbox256.sv
// rc_gearbox256: strips the 3-DW RC descriptor and realigns 256-bit completion payload to DW0 (optional RC_GEARBOX_ERR_CHECK_EN)
module rc_gearbox256 #(
  parameter int DATA_WIDTH  = 256,
  parameter int KEEP_WIDTH  = 8,
  parameter int TUSER_WIDTH = 75
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  m_axis_rc_tdata,
  input  logic                   m_axis_rc_tvalid,
  input  logic [TUSER_WIDTH-1:0] m_axis_rc_tuser,
  input  logic [KEEP_WIDTH-1:0]  m_axis_rc_tkeep,
  input  logic                   m_axis_rc_tlast,
  output logic                   m_axis_rc_tready,
  output logic [95:0]            rc_descriptor,
  output logic [10:0]            rc_dword_count,
  output logic [DATA_WIDTH-1:0]  rc_rd_data,
  output logic [KEEP_WIDTH-1:0]  rc_keep,
  output logic                   rc_valid,
  output logic                   rc_sop,
  output logic                   rc_last,
  input  logic                   rc_ready,
  output logic                   rc_error
);
  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;
  state_t state, state_n;
  logic [159:0] hold;
  logic [2:0] rem;
  logic first_out, free, acc, sop, emit, e_sop, e_last;
  logic [3:0] r;
  logic [255:0] e_data;
  logic [7:0] e_keep;
  logic unused_tuser;
  function automatic logic [7:0] mask(input logic [3:0] n);
    logic [8:0] m;
    m = (9'd1 << n) - 9'd1;
    return m[7:0];
  endfunction
  assign unused_tuser = ^{m_axis_rc_tuser[TUSER_WIDTH-1:33], m_axis_rc_tuser[31:0]};
  assign sop = m_axis_rc_tuser[32];
  assign free = !rc_valid || rc_ready;
  assign m_axis_rc_tready = !rst && (state != FLUSH) && free;
  assign acc = m_axis_rc_tvalid && m_axis_rc_tready;
  assign r = 4'($countones(m_axis_rc_tkeep));
  assign rc_dword_count = rc_descriptor[42:32];
  // next state and the beat to load into the output register
  always_comb begin
    state_n = state;
    emit = 1'b0;
    e_data = '0;
    e_keep = '0;
    e_sop = 1'b0;
    e_last = 1'b0;
    if (acc && sop) begin
      state_n = m_axis_rc_tlast ? IDLE : STREAM;
      emit = m_axis_rc_tlast;
      e_data = {96'b0, m_axis_rc_tdata[255:96]};
      e_keep = m_axis_rc_tkeep >> 3;
      e_sop = 1'b1;
      e_last = 1'b1;
    end else if (acc && state == STREAM) begin
      emit = 1'b1;
      e_data = {m_axis_rc_tdata[95:0], hold};
      e_sop = first_out;
      e_last = m_axis_rc_tlast && r <= 4'd3;
      e_keep = e_last ? mask(4'd5 + r) : 8'hFF;
      state_n = !m_axis_rc_tlast ? STREAM : (r <= 4'd3 ? IDLE : FLUSH);
    end else if (state == FLUSH && free) begin
      emit = 1'b1;
      e_data = {96'b0, hold};
      e_keep = mask({1'b0, rem});
      e_last = 1'b1;
      state_n = IDLE;
    end
  end
  // state, residual payload and single-entry output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hold <= '0;
      rem <= '0;
      first_out <= 1'b0;
      rc_descriptor <= '0;
      rc_rd_data <= '0;
      rc_keep <= '0;
      rc_valid <= 1'b0;
      rc_sop <= 1'b0;
      rc_last <= 1'b0;
    end else begin
      state <= state_n;
      if (acc) hold <= m_axis_rc_tdata[255:96];
      if (acc && sop) rc_descriptor <= m_axis_rc_tdata[95:0];
      if (acc && sop) first_out <= 1'b1;
      else if (acc && state == STREAM) first_out <= 1'b0;
      if (acc && state == STREAM) rem <= 3'(r - 4'd3);
      if (emit) begin
        rc_valid <= 1'b1;
        rc_rd_data <= e_data;
        rc_keep <= e_keep;
        rc_sop <= e_sop;
        rc_last <= e_last;
      end else if (rc_ready) rc_valid <= 1'b0;
    end
  end
`ifdef RC_GEARBOX_ERR_CHECK_EN
  logic err_tlp, sop_err;
  logic [15:0] err_cnt;
  assign sop_err = (|m_axis_rc_tdata[15:12]) || m_axis_rc_tdata[46];
  // flag every beat of a completion whose descriptor reports an error or poison
  always_ff @(posedge clk) begin
    if (rst) begin
      err_tlp <= 1'b0;
      err_cnt <= '0;
      rc_error <= 1'b0;
    end else begin
      if (acc && sop) err_tlp <= sop_err;
      if (acc && sop && sop_err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      if (emit) rc_error <= (acc && sop) ? sop_err : err_tlp;
    end
  end
`else
  assign rc_error = 1'b0;
`endif
endmodule
